// File: rtl/chess_move_sequencer_if.sv
// Board I/O bundle for chess_move_sequencer: keys, lock switch, step
// strobe, start position and the registered game outputs.
interface chess_move_sequencer_if #(
    parameter int CHESS_SQUARES = 64,
    parameter int SQUARE_WIDTH  = 8
);
    logic                                    Tick;
    logic                                    KeyLeft;
    logic                                    KeyRight;
    logic                                    KeyUp;
    logic                                    KeyDown;
    logic                                    LockSwitch;
    logic [CHESS_SQUARES*SQUARE_WIDTH-1:0]   InitLayout;
    logic [CHESS_SQUARES*SQUARE_WIDTH-1:0]   Layout;
    logic                                    Turn;
    logic [2:0]                              State;
    logic [$clog2(CHESS_SQUARES)-1:0]        CursorIdx;
    logic                                    MoveDone;
    logic                                    Reject;
    logic                                    GameOver;
    logic                                    Winner;

    modport master (
        output Tick, KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch, InitLayout,
        input  Layout, Turn, State, CursorIdx, MoveDone, Reject, GameOver, Winner
    );

    modport slave (
        input  Tick, KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch, InitLayout,
        output Layout, Turn, State, CursorIdx, MoveDone, Reject, GameOver, Winner
    );
endinterface

// File: rtl/chess_move_sequencer.sv
// Two-player move sequencer: cursor navigation, source/destination lock,
// move commit, king-capture and turn-timeout game end.
module chess_move_sequencer #(
    parameter int CHESS_SQUARES = 64,
    parameter int SQUARE_WIDTH  = 8,
    parameter int TURN_TICKS    = 600
) (
    input logic                   clock,
    input logic                   resetApp,
    chess_move_sequencer_if.slave bus
);
    localparam int IDX_W   = $clog2(CHESS_SQUARES);
    localparam int FLAG_W  = SQUARE_WIDTH - 4;
    localparam int TIMER_W = $clog2(TURN_TICKS + 1);
    localparam int BOARD_W = CHESS_SQUARES * SQUARE_WIDTH;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        SEL_SRC = 3'd1,
        SEL_DST = 3'd2,
        COMMIT  = 3'd3,
        OVER    = 3'd4
    } seqState_t;

    seqState_t           state, stateNext;
    logic [2:0]          cursorX, cursorY, cursorXNext, cursorYNext;
    logic [IDX_W-1:0]    srcIdx, srcIdxNext, dstIdx, dstIdxNext;
    logic [IDX_W-1:0]    cursorIdx, cursorIdxNext;
    logic                turn, turnNext;
    logic [TIMER_W-1:0]  timer, timerNext;
    logic                lockSample;
    logic                rejectReg, rejectNext;
    logic                gameOverReg, gameOverNext;
    logic                winnerReg, winnerNext;
    logic [BOARD_W-1:0]  layoutReg, layoutNext;

    logic [3:0]          cursorPiece;
    logic [2:0]          dstType;
    logic                lockEdge, timeout, ownPiece, srcShownNext;
    logic [3:0]          pieceSel;
    logic [FLAG_W-1:0]   flagSel;

    assign cursorIdx     = IDX_W'({cursorY, cursorX});
    assign cursorIdxNext = IDX_W'({cursorYNext, cursorXNext});
    assign cursorPiece   = layoutReg[cursorIdx*SQUARE_WIDTH +: 4];
    assign dstType       = layoutReg[dstIdx*SQUARE_WIDTH +: 3];
    assign lockEdge      = bus.LockSwitch & ~lockSample;
    assign ownPiece      = (cursorPiece[2:0] != 3'd0) && (cursorPiece[3] == turn);
    assign timeout       = ((state == SEL_SRC) || (state == SEL_DST)) && bus.Tick
                           && (timer == TIMER_W'(TURN_TICKS - 1));
    // The source stays highlighted through COMMIT and is cleared with the piece move.
    assign srcShownNext  = (stateNext == SEL_DST) || (stateNext == COMMIT);

    // Next-state, cursor, timer and lock bookkeeping.
    always_comb begin
        stateNext    = state;
        cursorXNext  = cursorX;
        cursorYNext  = cursorY;
        srcIdxNext   = srcIdx;
        dstIdxNext   = dstIdx;
        turnNext     = turn;
        timerNext    = timer;
        rejectNext   = 1'b0;
        gameOverNext = gameOverReg;
        winnerNext   = winnerReg;
        case (state)
            LOAD: stateNext = SEL_SRC;
            SEL_SRC, SEL_DST: begin
                if (timeout) begin
                    stateNext    = OVER;
                    gameOverNext = 1'b1;
                    winnerNext   = ~turn;
                end else begin
                    if (bus.Tick) begin
                        timerNext = timer + 1'b1;
                        if (!bus.KeyLeft)       cursorXNext = cursorX - 3'd1;
                        else if (!bus.KeyRight) cursorXNext = cursorX + 3'd1;
                        else if (!bus.KeyUp)    cursorYNext = cursorY - 3'd1;
                        else if (!bus.KeyDown)  cursorYNext = cursorY + 3'd1;
                    end
                    if (lockEdge) begin
                        if (state == SEL_SRC) begin
                            if (ownPiece) begin
                                srcIdxNext = cursorIdx;
                                stateNext  = SEL_DST;
                            end else begin
                                rejectNext = 1'b1;
                            end
                        end else if (cursorIdx == srcIdx) begin
                            stateNext = SEL_SRC;
                        end else if (ownPiece) begin
                            rejectNext = 1'b1;
                        end else begin
                            dstIdxNext = cursorIdx;
                            stateNext  = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                timerNext = '0;
                if (dstType == 3'd6) begin
                    stateNext    = OVER;
                    gameOverNext = 1'b1;
                    winnerNext   = turn;
                end else begin
                    turnNext  = ~turn;
                    stateNext = SEL_SRC;
                end
            end
            OVER: ;
            default: stateNext = LOAD;
        endcase
    end

    // Board image for the next cycle: piece nibbles plus cursor/source flags.
    always_comb begin
        layoutNext = layoutReg;
        pieceSel   = '0;
        flagSel    = '0;
        for (int unsigned i = 0; i < CHESS_SQUARES; i++) begin
            pieceSel = layoutReg[i*SQUARE_WIDTH +: 4];
            if (state == LOAD) begin
                pieceSel = bus.InitLayout[i*SQUARE_WIDTH +: 4];
            end else if (state == COMMIT) begin
                if (IDX_W'(i) == dstIdx)      pieceSel = layoutReg[srcIdx*SQUARE_WIDTH +: 4];
                else if (IDX_W'(i) == srcIdx) pieceSel = '0;
            end
            flagSel = '0;
            if (IDX_W'(i) == cursorIdxNext)                 flagSel[0] = 1'b1;
            if (srcShownNext && (IDX_W'(i) == srcIdxNext))  flagSel[1] = 1'b1;
            layoutNext[i*SQUARE_WIDTH +: SQUARE_WIDTH] = {flagSel, pieceSel};
        end
    end

    // Control and status registers.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state       <= LOAD;
            cursorX     <= 3'd2;
            cursorY     <= 3'd3;
            srcIdx      <= '0;
            dstIdx      <= '0;
            turn        <= 1'b0;
            timer       <= '0;
            lockSample  <= 1'b0;
            rejectReg   <= 1'b0;
            gameOverReg <= 1'b0;
            winnerReg   <= 1'b0;
        end else begin
            state       <= stateNext;
            cursorX     <= cursorXNext;
            cursorY     <= cursorYNext;
            srcIdx      <= srcIdxNext;
            dstIdx      <= dstIdxNext;
            turn        <= turnNext;
            timer       <= timerNext;
            lockSample  <= bus.LockSwitch;
            rejectReg   <= rejectNext;
            gameOverReg <= gameOverNext;
            winnerReg   <= winnerNext;
        end
    end

    // Board register; a timeout freezes the image exactly as it was shown.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            layoutReg <= '0;
        end else if ((state != OVER) && !timeout) begin
            layoutReg <= layoutNext;
        end
    end

    assign bus.Layout    = layoutReg;
    assign bus.Turn      = turn;
    assign bus.State     = state;
    assign bus.CursorIdx = cursorIdx;
    assign bus.MoveDone  = (state == COMMIT);
    assign bus.Reject    = rejectReg;
    assign bus.GameOver  = gameOverReg;
    assign bus.Winner    = winnerReg;
endmodule

// File: tb/tb_chess_move_sequencer.sv
// Bench for chess_move_sequencer: directed vector table, hand-written
// capture/timeout sequences and randomized play against a board model.
module tb_chess_move_sequencer;
    logic         clock = 1'b0;
    logic         resetApp = 1'b1;
    logic         tick = 1'b0, keyL = 1'b1, keyR = 1'b1, keyU = 1'b1, keyD = 1'b1, lock = 1'b0;
    logic [511:0] initLayout = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    chess_move_sequencer_if #(.CHESS_SQUARES(64), .SQUARE_WIDTH(8)) ifA ();
    chess_move_sequencer_if #(.CHESS_SQUARES(64), .SQUARE_WIDTH(8)) ifB ();

    assign ifA.Tick = tick;      assign ifB.Tick = tick;
    assign ifA.KeyLeft = keyL;   assign ifB.KeyLeft = keyL;
    assign ifA.KeyRight = keyR;  assign ifB.KeyRight = keyR;
    assign ifA.KeyUp = keyU;     assign ifB.KeyUp = keyU;
    assign ifA.KeyDown = keyD;   assign ifB.KeyDown = keyD;
    assign ifA.LockSwitch = lock; assign ifB.LockSwitch = lock;
    assign ifA.InitLayout = initLayout; assign ifB.InitLayout = initLayout;

    chess_move_sequencer #(.CHESS_SQUARES(64), .SQUARE_WIDTH(8), .TURN_TICKS(600)) dutA (
        .clock(clock), .resetApp(resetApp), .bus(ifA));
    chess_move_sequencer #(.CHESS_SQUARES(64), .SQUARE_WIDTH(8), .TURN_TICKS(4)) dutB (
        .clock(clock), .resetApp(resetApp), .bus(ifB));

    // ---------------- reference model (index 0 = dutA, 1 = dutB) ----------------
    int           mTT[2];
    int           mPhase[2], mCx[2], mCy[2], mSrc[2], mDst[2], mTimer[2];
    bit           mTurn[2], mLocked[2], mReject[2], mOver[2], mWinner[2], mLockPrev[2];
    bit [3:0]     mPc[2][64];
    logic [511:0] mImg[2];

    function automatic logic [511:0] img(input int m);
        logic [511:0] v;
        int f;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            f = 0;
            if (i == mCy[m] * 8 + mCx[m]) f += 1;
            if (mLocked[m] && i == mSrc[m]) f += 2;
            v[i*8 +: 8] = {4'(f), mPc[m][i]};
        end
        return v;
    endfunction

    task automatic modelReset(input int m);
        mPhase[m] = 0; mCx[m] = 2; mCy[m] = 3; mSrc[m] = 0; mDst[m] = 0; mTimer[m] = 0;
        mTurn[m] = 0; mLocked[m] = 0; mReject[m] = 0; mOver[m] = 0; mWinner[m] = 0;
        mLockPrev[m] = 0; mImg[m] = '0;
        for (int i = 0; i < 64; i++) mPc[m][i] = 4'h0;
    endtask

    task automatic modelStep(input int m, input bit t, input bit [3:0] k, input bit l);
        bit edgeSeen, frozen, own, captured;
        int cur;
        edgeSeen = l && !mLockPrev[m];
        mLockPrev[m] = l;
        frozen = (mPhase[m] == 4);
        mReject[m] = 0;
        case (mPhase[m])
            0: begin
                for (int i = 0; i < 64; i++) mPc[m][i] = initLayout[i*8 +: 4];
                mPhase[m] = 1;
            end
            1, 2: begin
                if (t && mTimer[m] == mTT[m] - 1) begin
                    mPhase[m] = 4; mOver[m] = 1; mWinner[m] = !mTurn[m]; frozen = 1;
                end else begin
                    cur = mCy[m] * 8 + mCx[m];
                    if (t) begin
                        mTimer[m]++;
                        if (k[3])      mCx[m] = (mCx[m] + 7) % 8;
                        else if (k[2]) mCx[m] = (mCx[m] + 1) % 8;
                        else if (k[1]) mCy[m] = (mCy[m] + 7) % 8;
                        else if (k[0]) mCy[m] = (mCy[m] + 1) % 8;
                    end
                    if (edgeSeen) begin
                        own = (mPc[m][cur][2:0] != 0) && (mPc[m][cur][3] == mTurn[m]);
                        if (mPhase[m] == 1) begin
                            if (own) begin mSrc[m] = cur; mLocked[m] = 1; mPhase[m] = 2; end
                            else mReject[m] = 1;
                        end else if (cur == mSrc[m]) begin
                            mLocked[m] = 0; mPhase[m] = 1;
                        end else if (own) begin
                            mReject[m] = 1;
                        end else begin
                            mDst[m] = cur; mPhase[m] = 3;
                        end
                    end
                end
            end
            3: begin
                captured = (mPc[m][mDst[m]][2:0] == 3'd6);
                mPc[m][mDst[m]] = mPc[m][mSrc[m]];
                mPc[m][mSrc[m]] = 4'h0;
                mLocked[m] = 0;
                mTimer[m] = 0;
                if (captured) begin mPhase[m] = 4; mOver[m] = 1; mWinner[m] = mTurn[m]; end
                else begin mTurn[m] = !mTurn[m]; mPhase[m] = 1; end
            end
            default: ;
        endcase
        if (!frozen) mImg[m] = img(m);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compareAll(input int m);
        string p;
        logic [2:0] st;
        logic [5:0] cu;
        logic tn, md, rj, go, wn;
        logic [511:0] ly;
        if (m == 0) begin
            p = "dutA"; st = ifA.State; cu = ifA.CursorIdx; tn = ifA.Turn; md = ifA.MoveDone;
            rj = ifA.Reject; go = ifA.GameOver; wn = ifA.Winner; ly = ifA.Layout;
        end else begin
            p = "dutB"; st = ifB.State; cu = ifB.CursorIdx; tn = ifB.Turn; md = ifB.MoveDone;
            rj = ifB.Reject; go = ifB.GameOver; wn = ifB.Winner; ly = ifB.Layout;
        end
        chk({p, ".State"},     512'(st), 512'(mPhase[m]));
        chk({p, ".CursorIdx"}, 512'(cu), 512'(mCy[m] * 8 + mCx[m]));
        chk({p, ".Turn"},      512'(tn), 512'(mTurn[m]));
        chk({p, ".MoveDone"},  512'(md), 512'(mPhase[m] == 3));
        chk({p, ".Reject"},    512'(rj), 512'(mReject[m]));
        chk({p, ".GameOver"},  512'(go), 512'(mOver[m]));
        chk({p, ".Winner"},    512'(wn), 512'(mWinner[m]));
        chk({p, ".Layout"},    ly, mImg[m]);
        if (md === 1'b1 && rj === 1'b1) chk({p, ".DoneAndReject"}, 512'(1), 512'(0));
    endtask

    // Drive inputs (keys given as pressed mask {L,R,U,D}), clock once, check.
    task automatic doCycle(input bit t, input bit [3:0] k, input bit l);
        tick = t; keyL = !k[3]; keyR = !k[2]; keyU = !k[1]; keyD = !k[0]; lock = l;
        @(posedge clock);
        modelStep(0, t, k, l);
        modelStep(1, t, k, l);
        @(negedge clock);
        compareAll(0);
        compareAll(1);
    endtask

    task automatic applyReset();
        resetApp = 1'b1;
        #1;
        modelReset(0);
        modelReset(1);
        compareAll(0);
        compareAll(1);
        chk("resetCursor", 512'(ifA.CursorIdx), 512'(26));
        @(posedge clock);
        @(negedge clock);
        compareAll(0);
        compareAll(1);
        resetApp = 1'b0;
    endtask

    function automatic bit [2:0] backRank(input int f);
        case (f)
            0, 7: return 3'd4;
            1, 6: return 3'd2;
            2, 5: return 3'd3;
            3:    return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        bit       tick;
        bit [3:0] keys;
        bit       lock;
        bit [2:0] st;
        bit [5:0] cur;
        bit       rej;
        bit       done;
        bit       turn;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit t, input bit [3:0] k, input bit l, input bit [2:0] s,
                          input bit [5:0] c, input bit r, input bit d, input bit tn);
        vec_t v;
        v.tick = t; v.keys = k; v.lock = l; v.st = s; v.cur = c; v.rej = r; v.done = d; v.turn = tn;
        vecs.push_back(v);
    endtask

    localparam bit [3:0] KN = 4'b0000, KL = 4'b1000, KR = 4'b0100, KU = 4'b0010, KD = 4'b0001;

    initial begin
        bit [3:0] pc;
        bit [3:0] k;
        bit lockState;
        logic [511:0] frozenImg;

        mTT[0] = 600;
        mTT[1] = 4;
        for (int i = 0; i < 64; i++) begin
            pc = 4'h0;
            if (i < 8)                  pc = {1'b1, backRank(i)};
            else if (i < 16)            pc = 4'h9;
            else if (i >= 48 && i < 56) pc = 4'h1;
            else if (i >= 56)           pc = {1'b0, backRank(i - 56)};
            initLayout[i*8 +: 8] = {4'(i * 7 + 3), pc};
        end

        addVec(0, KN, 0, 1, 26, 0, 0, 0);
        addVec(0, KN, 0, 1, 26, 0, 0, 0);
        addVec(1, KL, 0, 1, 25, 0, 0, 0);
        addVec(1, KL, 0, 1, 24, 0, 0, 0);
        addVec(1, KL, 0, 1, 31, 0, 0, 0);
        addVec(1, KL | KU, 0, 1, 30, 0, 0, 0);
        addVec(0, KN, 1, 1, 30, 1, 0, 0);
        addVec(0, KN, 0, 1, 30, 0, 0, 0);
        addVec(1, KU, 0, 1, 22, 0, 0, 0);
        addVec(1, KU, 0, 1, 14, 0, 0, 0);
        addVec(0, KN, 1, 1, 14, 1, 0, 0);
        addVec(0, KN, 0, 1, 14, 0, 0, 0);
        addVec(1, KL, 0, 1, 13, 0, 0, 0);
        addVec(1, KL, 0, 1, 12, 0, 0, 0);
        addVec(1, KD, 0, 1, 20, 0, 0, 0);
        addVec(1, KD, 0, 1, 28, 0, 0, 0);
        addVec(1, KD, 0, 1, 36, 0, 0, 0);
        addVec(1, KD, 0, 1, 44, 0, 0, 0);
        addVec(1, KD, 0, 1, 52, 0, 0, 0);
        addVec(0, KN, 1, 2, 52, 0, 0, 0);
        addVec(0, KN, 0, 2, 52, 0, 0, 0);
        addVec(0, KN, 1, 1, 52, 0, 0, 0);
        addVec(0, KN, 0, 1, 52, 0, 0, 0);
        addVec(0, KN, 1, 2, 52, 0, 0, 0);
        addVec(0, KN, 0, 2, 52, 0, 0, 0);
        addVec(1, KR, 0, 2, 53, 0, 0, 0);
        addVec(0, KN, 1, 2, 53, 1, 0, 0);
        addVec(0, KN, 0, 2, 53, 0, 0, 0);
        addVec(1, KL, 0, 2, 52, 0, 0, 0);
        addVec(1, KU, 0, 2, 44, 0, 0, 0);
        addVec(1, KU, 0, 2, 36, 0, 0, 0);
        addVec(0, KN, 1, 3, 36, 0, 1, 0);
        addVec(0, KN, 0, 1, 36, 0, 0, 1);
        addVec(0, KL, 0, 1, 36, 0, 0, 1);

        @(negedge clock);
        applyReset();
        foreach (vecs[i]) begin
            doCycle(vecs[i].tick, vecs[i].keys, vecs[i].lock);
            chk($sformatf("vec%0d.State", i),    512'(ifA.State),     512'(vecs[i].st));
            chk($sformatf("vec%0d.Cursor", i),   512'(ifA.CursorIdx), 512'(vecs[i].cur));
            chk($sformatf("vec%0d.Reject", i),   512'(ifA.Reject),    512'(vecs[i].rej));
            chk($sformatf("vec%0d.MoveDone", i), 512'(ifA.MoveDone),  512'(vecs[i].done));
            chk($sformatf("vec%0d.Turn", i),     512'(ifA.Turn),      512'(vecs[i].turn));
            if (i == 1)
                chk("loadSquare26", 512'(ifA.Layout[215:208]), 512'({4'h1, initLayout[211:208]}));
        end
        chk("movedPiece36", 512'(ifA.Layout[291:288]), 512'(4'h1));
        chk("vacated52",    512'(ifA.Layout[419:416]), 512'(4'h0));

        // White pawn captures the black king at square 4.
        applyReset();
        doCycle(0, KN, 0);
        doCycle(0, KN, 0);
        doCycle(1, KR, 0);
        doCycle(1, KR, 0);
        doCycle(1, KD, 0);
        doCycle(1, KD, 0);
        doCycle(1, KD, 0);
        doCycle(0, KN, 1);
        doCycle(0, KN, 0);
        doCycle(1, KD, 0);
        doCycle(1, KD, 0);
        chk("kingCursor", 512'(ifA.CursorIdx), 512'(4));
        doCycle(0, KN, 1);
        chk("kingCommitDone", 512'(ifA.MoveDone), 512'(1));
        doCycle(0, KN, 0);
        chk("kingState",    512'(ifA.State),    512'(4));
        chk("kingGameOver", 512'(ifA.GameOver), 512'(1));
        chk("kingWinner",   512'(ifA.Winner),   512'(0));
        chk("kingTurn",     512'(ifA.Turn),     512'(0));
        chk("kingSquare4",  512'(ifA.Layout[39:32]), 512'({4'h1, 4'h1}));
        frozenImg = mImg[0];
        for (int i = 0; i < 6; i++) begin
            doCycle(1, 4'(1 << (i % 4)), i[0]);
            chk($sformatf("overFrozen%0d", i), ifA.Layout, frozenImg);
            chk($sformatf("overState%0d", i),  512'(ifA.State), 512'(4));
        end

        // Timeout on the 4th tick beats a lock edge and a key in the same cycle.
        applyReset();
        doCycle(0, KN, 0);
        doCycle(0, KN, 0);
        doCycle(1, KD, 0);
        doCycle(1, KD, 0);
        doCycle(1, KD, 0);
        chk("toPreGameOver", 512'(ifB.GameOver), 512'(0));
        doCycle(0, KN, 1);
        chk("toSrcLocked", 512'(ifB.State), 512'(2));
        doCycle(0, KN, 0);
        doCycle(1, KD, 1);
        chk("toState",    512'(ifB.State),     512'(4));
        chk("toGameOver", 512'(ifB.GameOver),  512'(1));
        chk("toWinner",   512'(ifB.Winner),    512'(1));
        chk("toMoveDone", 512'(ifB.MoveDone),  512'(0));
        chk("toReject",   512'(ifB.Reject),    512'(0));
        chk("toCursor",   512'(ifB.CursorIdx), 512'(50));
        chk("toSquare50", 512'(ifB.Layout[407:400]), 512'({4'h3, 4'h1}));
        doCycle(0, KN, 0);
        chk("toMoveDoneAfter", 512'(ifB.MoveDone), 512'(0));

        // Randomized play with occasional resets.
        applyReset();
        lockState = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) applyReset();
            k = 4'b0000;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) k[b] = 1'b1;
            if ($urandom_range(0, 9) < 3) lockState = !lockState;
            doCycle(1'($urandom_range(0, 1)), k, lockState);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
